// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver.
// The state encoding includes PARITY even when SERIAL_TX_PARITY_EN is undefined,
// so that both builds use the same 3-bit state values.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Total frame length in clocks: start + data + optional parity + stop.
    function automatic int frame_clks(input int data_w, input int clks_per_bit, input bit parity_en);
        return (data_w + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_period_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
// 'last' flags the final clock of the current bit period.
module bit_period_cnt
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    // Count clocks within a bit period; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            if (last) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in serial-out frame transmitter: start bit, DATA_W data bits LSB
// first, optional even parity bit, stop bit; each bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts the parity bit.
// All outputs are registered; reset is synchronous and active-low.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [IDX_W-1:0]  idx_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q;
`endif

    logic [CNT_W-1:0]  cnt_count;
    logic              cnt_last;
    logic              cnt_pre_last;
    logic              cnt_clear;

    // The counter is held at zero while idle so that the accepting edge starts
    // the start bit with a full period.
    assign cnt_clear    = (state_q == IDLE);
    assign cnt_pre_last = (cnt_count == CNT_W'(CLKS_PER_BIT - 2));
    assign shift_d      = shift_q >> 1;

    bit_period_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (~cnt_clear),
        .count  (cnt_count),
        .last   (cnt_last)
    );

    // Frame sequencer with registered line, handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= LINE_IDLE;
                    busy_q <= 1'b0;
                    // ready_q gates the handshake so the first edge after
                    // reset only raises in_ready.
                    if (in_valid && ready_q) begin
                        shift_q  <= in_data;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q <= ^in_data;
`endif
                        tx_q     <= START_BIT;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        state_q  <= START;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        if (idx_q == IDX_W'(DATA_W - 1)) begin
                            idx_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= STOP_BIT;
`endif
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            shift_q <= shift_d;
                            tx_q    <= shift_d[0];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (cnt_last) begin
                        state_q <= STOP;
                        tx_q    <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    // Flag the final stop-bit clock one edge ahead so the
                    // registered pulse lines up with it.
                    if (cnt_pre_last) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                    if (cnt_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= LINE_IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= LINE_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: table-driven frames, directed
// multi-cycle sequences and randomized traffic against a frame-position model.
module tb_serial_frame_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NSLOT = DW + 2 + PAR;
    localparam int FL    = NSLOT * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    always #5 clk = ~clk;

    serial_frame_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: position within the frame ----------------
    bit         m_active = 1'b0;
    bit         m_ready  = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_word   = 8'h00;

    function automatic logic slot_bit(input int s, input logic [7:0] w);
        if (s == 0) return 1'b0;
        if (s <= DW) return w[s-1];
        if (PAR == 1 && s == DW + 1) return ^w;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_ready  <= 1'b0;
            m_pos    <= 0;
        end else if (m_active) begin
            if (m_pos == FL - 1) begin
                m_active <= 1'b0;
                m_ready  <= 1'b1;
            end else begin
                m_pos <= m_pos + 1;
            end
        end else if (m_ready && in_valid) begin
            m_active <= 1'b1;
            m_pos    <= 0;
            m_word   <= in_data;
        end else begin
            m_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx",   32'(tx),       32'(m_active ? slot_bit(m_pos / CPB, m_word) : 1'b1));
            check("model_busy", 32'(busy),     32'(m_active));
            check("model_done", 32'(tx_done),  32'(m_active && (m_pos == FL - 1)));
            check("model_rdy",  32'(in_ready), 32'(m_active ? (m_pos == FL - 1) : m_ready));
        end
    end

    // ---------------- directed frame table ----------------
    typedef struct {
        logic [7:0]  data;
        logic [11:0] slots;   // bit i = expected line level in slot i
    } vec_t;

    vec_t tbl [7];

    // Send table entry idx; mode 0 drops in_valid after acceptance, mode 1 keeps
    // it high and presents nxt immediately, mode 2 keeps it high with junk and
    // switches to nxt mid-frame.
    task automatic send_frame(input int idx, input int mode, input logic [7:0] nxt, input bit expect_b2b);
        logic rec_tx   [0:63];
        logic rec_busy [0:63];
        logic rec_done [0:63];
        int   waited;
        bit   found;
        int   nbusy;
        int   ndone;
        in_valid = 1'b1;
        in_data  = tbl[idx].data;
        found    = 1'b0;
        waited   = 0;
        while (!found && waited < 4 * FL) begin
            @(negedge clk);
            waited++;
            if (busy === 1'b1) found = 1'b1;
        end
        if (!found) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (expect_b2b) check("b2b_gap_clocks", 32'(waited), 32'd1);
        for (int k = 0; k <= FL; k++) begin
            if (k > 0) @(negedge clk);
            rec_tx[k]   = tx;
            rec_busy[k] = busy;
            rec_done[k] = tx_done;
            if (k == 0) begin
                if (mode == 0) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end else if (mode == 1) begin
                    in_data = nxt;
                end else begin
                    in_data = 8'($urandom);
                end
            end
            if (mode == 2 && k == 15) in_data = nxt;
        end
        for (int s = 0; s < NSLOT; s++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("frame%0d_slot%0d", idx, s), 32'(rec_tx[s*CPB + c]), 32'(tbl[idx].slots[s]));
            end
        end
        nbusy = 0;
        ndone = 0;
        for (int k = 0; k <= FL; k++) begin
            if (rec_busy[k] === 1'b1) nbusy++;
            if (rec_done[k] === 1'b1) ndone++;
        end
        check("busy_clocks",   32'(nbusy), 32'(FL));
        check("done_count",    32'(ndone), 32'd1);
        check("done_position", 32'(rec_done[FL-1]), 32'd1);
        check("gap_tx",        32'(rec_tx[FL]), 32'd1);
    endtask

    initial begin
        int waited;
        int ndone;
`ifdef SERIAL_TX_PARITY_EN
        tbl[0] = '{8'hA5, 12'b010101001010};
        tbl[1] = '{8'h00, 12'b010000000000};
        tbl[2] = '{8'hFF, 12'b010111111110};
        tbl[3] = '{8'h3C, 12'b010001111000};
        tbl[4] = '{8'h81, 12'b010100000010};
        tbl[5] = '{8'h07, 12'b011000001110};
        tbl[6] = '{8'h03, 12'b010000000110};
`else
        tbl[0] = '{8'hA5, 12'b001101001010};
        tbl[1] = '{8'h00, 12'b001000000000};
        tbl[2] = '{8'hFF, 12'b001111111110};
        tbl[3] = '{8'h3C, 12'b001001111000};
        tbl[4] = '{8'h81, 12'b001100000010};
        tbl[5] = '{8'h07, 12'b001000001110};
        tbl[6] = '{8'h03, 12'b001000000110};
`endif

        // Reset for three clocks, then release.
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx",    32'(tx),       32'd1);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(tx_done),  32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(in_ready), 32'd1);
        check("idle_tx",             32'(tx),       32'd1);

        // Table-driven single frames.
        for (int i = 0; i < 7; i++) begin
            send_frame(i, 0, 8'h00, 1'b0);
            repeat (2) @(negedge clk);
        end

        // Back-to-back 00 then FF with in_valid held.
        send_frame(1, 1, 8'hFF, 1'b0);
        send_frame(2, 0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);

        // Changing in_data while busy; 3C follows right after tx_done.
        send_frame(0, 2, 8'h3C, 1'b0);
        send_frame(3, 0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 aborts the frame without tx_done.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        waited   = 0;
        while (busy !== 1'b1 && waited < 4 * FL) begin
            @(negedge clk);
            waited++;
        end
        check("abort_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tx",   32'(tx),      32'd1);
        check("abort_busy", 32'(busy),    32'd0);
        check("abort_done", 32'(tx_done), 32'd0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (tx_done === 1'b1) ndone++;
        end
        rst = 1'b1;
        repeat (FL) begin
            @(negedge clk);
            if (tx_done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        send_frame(4, 0, 8'h00, 1'b0);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2 * FL) @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter: drives the bit stream that the lab's flop-based capture and receive chains sample.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Emits one frame on a single line: start bit (0), data LSB first, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Sits between a register/FIFO source and the external serial pin.

Parameters:
- DATA_W, 8, payload bits per frame (1..16).
- CLKS_PER_BIT, 868, clocks per serial bit (>=2); 100 MHz / 115200 baud.
- CNT_W, $clog2(CLKS_PER_BIT), width of bit-period counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-low: asserted when 0, sampled on posedge clk only.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  source has a word.
- in_ready  output  1  transmitter can accept a word.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse on the last clock of the stop bit.

Behaviour:
- Reset (rst=0 at posedge):
  - tx=1, in_ready=0, busy=0, tx_done=0.
  - State IDLE; counters and shift register cleared.
  - First posedge with rst=1: in_ready=1.
- Reset mid-frame aborts immediately: tx=1 on that edge and the partial frame is discarded. No tx_done is issued for the aborted frame.
- State machine states: IDLE, START, DATA, [PARITY], STOP. All outputs are registered.
- IDLE:
  - in_ready=1, tx=1.
  - Handshake completes at a posedge with in_valid & in_ready. That edge captures in_data into the shift register, sets in_ready=0 and busy=1, drives tx=0, and enters START.
  - in_data is ignored when in_valid=0.
- START: tx=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT clocks, then shift right and increment the index.
  - After DATA_W bits, go to STOP (or PARITY when enabled).
- STOP:
  - tx=1 for CLKS_PER_BIT clocks.
  - On its final clock: tx_done=1 and in_ready=1; next state IDLE.
- Latency:
  - tx falls on the same edge that accepts the word.
  - Frame length is (DATA_W+2)*CLKS_PER_BIT clocks, plus CLKS_PER_BIT when parity is enabled.
- Back-to-back: in_valid held high with new data is accepted on the first IDLE edge after tx_done. The inter-frame gap is exactly 1 clock of tx=1 beyond the stop bit.
- in_data or in_valid changing while busy has no effect.
- Bit-period counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Never exceeds CLKS_PER_BIT-1.
- Bit index: saturates at DATA_W-1; it is not reused across states.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx = XOR of all DATA_W captured bits (even parity) for CLKS_PER_BIT clocks.
  - Frame grows by CLKS_PER_BIT clocks.
- Undefined: no PARITY state or logic exists; DATA goes directly to STOP.

Decomposition:
- Package serial_pkg holds:
  - State encoding enum (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits, also used when parity is off).
  - Constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - A function computing frame length in clocks, for the bench.
- Sub-module bit_period_cnt:
  - Inputs clk, rst, clear, enable.
  - Outputs count and last (count==CLKS_PER_BIT-1).
  - Reused by the matching receiver.

Test Plan:
- Reset/idle: rst=0 for 3 clocks, then release → tx=1, busy=0, tx_done=0 throughout reset; in_ready=1 on the first edge after release.
- Single frame (CLKS_PER_BIT=4, DATA_W=8, in_data=8'hA5, one-cycle in_valid):
  - tx sequence per 4-clock slot: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done pulses once at clock 40 after acceptance; busy is high for 40 clocks.
- Back-to-back: in_valid held high with 8'h00 then 8'hFF → second start bit falls exactly 1 clock after the first tx_done; 8'h00 frame is ten slots 0,0..0,1; 8'hFF frame is 0,1..1,1.
- Ignore while busy: change in_data to 8'h3C mid-frame with in_valid=1 → the current frame is unchanged and the 8'h3C word is accepted only after tx_done.
- Reset mid-frame: assert rst=0 during data bit 3 → tx=1 on that edge, no tx_done; after release, a new frame of 8'h81 is correct.
- Parity (SERIAL_TX_PARITY_EN defined): 8'h07 → parity slot=1, frame 44 clocks; 8'h03 → parity slot=0.
